// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller and its bench.
package serial_adder_ctrl_pkg;

    // Legal operand width range
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder; the one shared arithmetic cell of the serial adder.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder stepped LSB-first over WIDTH
// bits, with a registered sum/carry-out and a one-cycle done pulse.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("serial_adder_ctrl: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_s, fa_cout;

    // The shared cell always looks at the operand LSBs and the carry flop.
    full_adder u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // Next-state, datapath stepping and output-register loads.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
                sum_sh_d = sum_sh_q >> 1;
                sum_sh_d[WIDTH-1] = fa_s;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = sum_sh_d;
                    cout_d  = fa_cout;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status flags are registered copies of the upcoming state.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers; reset discards any running add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit and a 1-bit instance,
// with a scoreboard of expected {cout,sum} popped on every done pulse.
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic busy1, done1, sum1, cout1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [W:0] sb_q[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                logic [W:0] e;
                e = sb_q.pop_front();
                check("sb_result", 64'({cout, sum}), 64'(e));
            end
        end
        if (rst_n && (busy || done))
            check("busy_done_excl", 64'(busy & done), 64'(0));
    end

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // One accepted operation with full latency/busy/done timing checks.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(negedge clk);
        start = 1'b1; a = x; b = y; cin = c;
        sb_q.push_back(model(x, y, c));
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("run_busy", 64'(busy), 64'(1));
        end
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(1));
        check("done_busy_low", 64'(busy), 64'(0));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
    endtask

    initial begin
        int d0;
        // Reset state
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        check("rst_w1", 64'({busy1, done1, sum1, cout1}), 64'(0));
        @(negedge clk); rst_n = 1'b1;

        // Basic add, carry out, full carry propagation
        run_op(8'h3C, 8'h5A, 1'b0);
        check("sum_3c5a", 64'({cout, sum}), 64'(9'h096));
        run_op(8'hFF, 8'h01, 1'b0);
        check("sum_ff01", 64'({cout, sum}), 64'(9'h100));
        run_op(8'hFF, 8'hFF, 1'b1);
        check("sum_ffff1", 64'({cout, sum}), 64'(9'h1FF));

        // start and operand churn during RUN must be ignored
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        sb_q.push_back(model(8'h10, 8'h20, 1'b0));
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("ign_busy", 64'(busy), 64'(1));
            start = (i == 2);
            a = (i == 2) ? 8'hAA : 8'($urandom);
            b = (i == 2) ? 8'h55 : 8'($urandom);
            cin = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        check("ign_done", 64'(done), 64'(1));
        check("ign_sum", 64'({cout, sum}), 64'(9'h030));
        repeat (5) @(negedge clk);
        check("ign_one_done", 64'(done_cnt - d0), 64'(1));
        check("ign_hold", 64'({cout, sum}), 64'(9'h030));

        // Asynchronous reset in the 4th RUN cycle; discarded op, no done
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("hold_in_run", 64'({cout, sum}), 64'(9'h030));
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_sum", 64'({cout, sum}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("arst_no_done", 64'(done_cnt - d0), 64'(0));
        run_op(8'h01, 8'h01, 1'b0);
        check("post_rst_sum", 64'({cout, sum}), 64'(9'h002));

        // start held high: one operation every W+2 cycles
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0;
        repeat (3) sb_q.push_back(model(8'h7F, 8'h01, 1'b0));
        @(posedge clk);
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < W + 2; k++) begin
                @(negedge clk);
                check("b2b_busy", 64'(busy), 64'(k < W));
                check("b2b_done", 64'(done), 64'(k == W));
                if (k == W) check("b2b_sum", 64'({cout, sum}), 64'(9'h080));
                if (j == 2 && k == W + 1) start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        check("b2b_count", 64'(done_cnt - d0), 64'(3));

        // WIDTH=1 instance
        @(negedge clk);
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        @(negedge clk);
        check("w1_busy", 64'({busy1, done1}), 64'(2'b10));
        @(negedge clk);
        check("w1_done", 64'({busy1, done1}), 64'(2'b01));
        check("w1_result", 64'({cout1, sum1}), 64'(2'b11));
        @(negedge clk);
        check("w1_done_low", 64'(done1), 64'(0));

        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that time-shares one full_adder cell across a WIDTH-bit addition, one bit per clock, LSB first.
- Latches operands on a start request, steps the shared cell through every bit position, and holds a carry flop between steps.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Area-cheap alternative to ripple adders for slow-path arithmetic.

Parameters:
- WIDTH, 8, operand/result bit width; legal range 1..64. Out-of-range values stop elaboration with an error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  carry-in; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out

Behaviour:
- Reset:
  - rst_n low forces state IDLE immediately, without waiting for a clock edge.
  - busy, done, sum, cout all 0; internal shift registers, carry flop and bit counter all 0.
  - Applies at any time, including mid-RUN. The in-flight operation is discarded and produces no done.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - latch a and b into operand shift registers;
  - carry flop <= cin; bit counter <= 0;
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - The shared full_adder sees operand LSBs plus the carry flop.
  - Its S output shifts into the MSB end of the internal sum shift register; operands shift right by one.
  - carry flop <= Cout; counter increments.
  - On the edge where the counter reaches WIDTH-1 (the WIDTH-th RUN edge, E0+WIDTH), move to DONE. On that same edge, load the sum and cout outputs from the completed shift register and carry.
- DONE:
  - done=1 for exactly one cycle.
  - The next edge returns to IDLE unconditionally.
- Latency:
  - done is high in the cycle following edge E0+WIDTH.
  - The next start is accepted at edge E0+WIDTH+2 at the earliest.
  - With start held high, back-to-back operations run every WIDTH+2 cycles.
- busy is 1 exactly in RUN (WIDTH cycles). busy and done are never high together.
- start in RUN or DONE is ignored and is not queued.
- Changes on a, b or cin after E0 have no effect on the running operation.
- sum and cout hold their last result from DONE through IDLE and RUN until the next DONE overwrites them. Only reset clears them.
- Arithmetic is modulo 2^WIDTH. cout is the carry out of bit WIDTH-1.
- WIDTH=1: one RUN cycle, then DONE.
- Counter width is clog2(WIDTH), minimum 1 bit.
- No combinational path from any input to any output; all outputs are registers.

Decomposition:
- Shared header (included by the controller and its bench):
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - WIDTH legal-range bounds.
- One sub-module: the existing full_adder, instanced once as the shared cell (ports A, B, Cin, S, Cout).
- The FSM, counter, shift registers and carry flop all live in serial_adder_ctrl; no further sub-modules.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h5A, cin=0, start pulsed at edge E0:
  - busy high 8 cycles; done pulse after E0+8; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1 (full carry propagation).
- Start 8'h10+8'h20; during RUN pulse start with 8'hAA+8'h55 and change a/b every cycle:
  - exactly one done; sum=8'h30, cout=0;
  - sum/cout stay 8'h30/0 until the next accepted start's DONE.
- Assert rst_n=0 asynchronously, away from any clock edge, during the 4th RUN cycle:
  - busy/done/sum/cout drop to 0 immediately; no done appears.
  - After release, 8'h01+8'h01 gives sum=8'h02, done after 8 cycles.
- start held high continuously, same operands 8'h7F+8'h01:
  - done pulses every 10 cycles; sum=8'h80, cout=0 each time; busy low in the DONE and IDLE cycles.
- WIDTH=1 build: a=1, b=1, cin=1 → done 1 cycle after the RUN cycle; sum=1, cout=1.
